// File: rtl/divmul_seq.sv
// Iterative signed multiply/divide unit feeding the HI/LO registers of the multicycle core.
// Multiply is LSB-first shift-add, divide is MSB-first restoring; both take WIDTH iterations plus a sign-fix cycle.
module divmul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, next_state;

  // Operand magnitudes, signs and the latched operation.
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   a_orig;
  logic               sign_a;
  logic               sign_b;
  logic               op_mul;
  logic               zero_div;
  logic [CNT_W-1:0]   count;

  // Mult: {upper partial sum, multiplier shifting out}. Div: lower half holds dividend/quotient.
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   rem;

  logic               accept;
  logic               b_is_zero;
  logic [WIDTH:0]     mult_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic               neg_result;
  logic [2*WIDTH-1:0] prod_res;
  logic [WIDTH-1:0]   quo_res;
  logic [WIDTH-1:0]   rem_res;

  // Unsigned magnitude; the most negative value maps onto itself, which is the right unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  assign accept    = (state == IDLE) && start;
  assign b_is_zero = (b == '0);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: next_state gets its default first so no path through the case leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          next_state = (!op && b_is_zero) ? FIX : RUN;
        end
      end
      RUN: begin
        if (count == '0) begin
          next_state = FIX;
        end
      end
      FIX:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // One iteration of each algorithm, evaluated every cycle and used only in RUN.
  always_comb begin
    mult_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);
    div_shift = {rem, acc[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, mag_b});
    // Only used when div_ge, where the true difference is below mag_b and fits WIDTH bits.
    div_diff  = div_shift[WIDTH-1:0] - mag_b;
  end

  // Sign correction applied in FIX: remainder follows the dividend, quotient/product the sign product.
  always_comb begin
    neg_result = sign_a ^ sign_b;
    prod_res   = neg_result ? -acc : acc;
    quo_res    = neg_result ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_res    = sign_a ? -rem : rem;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mag_a    <= '0;
      mag_b    <= '0;
      a_orig   <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      op_mul   <= 1'b0;
      zero_div <= 1'b0;
      count    <= '0;
      acc      <= '0;
      rem      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            mag_a    <= magnitude(a);
            mag_b    <= magnitude(b);
            a_orig   <= a;
            sign_a   <= a[WIDTH-1];
            sign_b   <= b[WIDTH-1];
            op_mul   <= op;
            zero_div <= !op && b_is_zero;
            count    <= CNT_W'(WIDTH - 1);
            // Multiplier (mult) or dividend (div) seeds the low half; the upper half starts clear.
            acc      <= {{WIDTH{1'b0}}, op ? magnitude(b) : magnitude(a)};
            rem      <= '0;
            div_zero <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          count <= count - 1'b1;
          if (op_mul) begin
            acc <= {mult_sum, acc[WIDTH-1:1]};
          end else begin
            rem <= div_ge ? div_diff : div_shift[WIDTH-1:0];
            acc <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], div_ge};
          end
        end
        FIX: begin
          if (zero_div) begin
            hi       <= a_orig;
            lo       <= '0;
            div_zero <= 1'b1;
          end else if (op_mul) begin
            {hi, lo} <= prod_res;
          end else begin
            hi <= rem_res;
            lo <= quo_res;
          end
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divmul_seq.sv
// Scoreboard bench for divmul_seq: stimulus pushes expected results computed with plain
// signed arithmetic; a negedge monitor pops and compares on every done pulse.
module tb_divmul_seq;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           done_cyc;
  } exp_t;

  exp_t sb_q[$];

  divmul_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: signed 64-bit arithmetic; SV division truncates toward zero and % follows the dividend.
  function automatic exp_t model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                                 input int dc);
    exp_t   m;
    longint sx;
    longint sy;
    longint p;
    longint q;
    longint r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    m.done_cyc = dc;
    m.dz = 1'b0;
    if (o) begin
      p = sx * sy;
      m.hi = p[63:32];
      m.lo = p[31:0];
    end else if (y == 0) begin
      m.hi = x;
      m.lo = '0;
      m.dz = 1'b1;
    end else begin
      q = sx / sy;
      r = sx % sy;
      m.hi = r[31:0];
      m.lo = q[31:0];
    end
    return m;
  endfunction

  // Monitor: compare every done pulse with the oldest expectation.
  always @(negedge clk) begin
    if (reset) begin
      if (done && busy) check("done_with_busy", {63'd0, busy}, 64'd0);
      if (done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("hi", {32'd0, hi}, {32'd0, e.hi});
          check("lo", {32'd0, lo}, {32'd0, e.lo});
          check("div_zero", {63'd0, div_zero}, {63'd0, e.dz});
          check("done_cycle", 64'(cyc), 64'(e.done_cyc));
        end
      end
    end
  end

  // Call at a negedge; returns #1 after the sampling edge.
  task automatic issue(input logic o, input logic [W-1:0] x, input logic [W-1:0] y, input bit push);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 1'($urandom);
    a     = $urandom;
    b     = $urandom;
    if (push) sb_q.push_back(model(o, x, y, cyc + ((!o && y == 0) ? 1 : W + 1)));
  endtask

  // Returns at the negedge where done is seen (the done cycle).
  task automatic wait_done(input bit chk_busy, input int exp_busy);
    int  nbusy;
    bit  seen;
    nbusy = 0;
    seen  = 1'b0;
    for (int i = 0; i < W + 8; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) nbusy++;
    end
    check("done_seen", {63'd0, seen}, 64'd1);
    if (chk_busy) check("busy_cycles", 64'(nbusy), 64'(exp_busy));
  endtask

  task automatic run_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    issue(o, x, y, 1'b1);
    wait_done(1'b1, (!o && y == 0) ? 1 : W + 1);
    @(negedge clk);
  endtask

  function automatic logic [W-1:0] pick_operand();
    unique case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return W'($urandom_range(0, 15));
      3:       return -W'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b0;
    start = 1'b0;
    op    = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_div_zero", {63'd0, div_zero}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Directed cases.
    run_op(1'b1, 32'd7, 32'hFFFF_FFFD);
    run_op(1'b1, 32'h8000_0000, 32'h8000_0000);
    run_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(1'b0, 32'hFFFF_FFF9, 32'd2);
    run_op(1'b0, 32'd7, 32'hFFFF_FFFE);
    run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(1'b0, 32'h1234_5678, 32'd0);

    // The next accepted start clears div_zero at once.
    issue(1'b1, 32'd5, 32'd6, 1'b1);
    check("div_zero_cleared", {63'd0, div_zero}, 64'd0);
    check("busy_after_start", {63'd0, busy}, 64'd1);
    wait_done(1'b1, W + 1);

    // Back-to-back start in the done cycle, then a start while busy that must be ignored.
    issue(1'b0, 32'd100, 32'd7, 1'b1);
    repeat (9) @(negedge clk);
    start = 1'b1;
    op    = 1'b1;
    a     = 32'h0BAD_F00D;
    b     = 32'h0000_0003;
    @(negedge clk);
    start = 1'b0;
    wait_done(1'b0, 0);
    issue(1'b1, 32'hFFFF_0000, 32'h0001_0001, 1'b1);
    wait_done(1'b1, W + 1);
    @(negedge clk);

    // Reset mid-operation.
    issue(1'b1, 32'd9, 32'd9, 1'b0);
    repeat (14) @(negedge clk);
    #3 reset = 1'b0;
    #1;
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_done", {63'd0, done}, 64'd0);
    check("midrst_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (W + 6) @(negedge clk);
    run_op(1'b0, 32'hFFFF_FF9C, 32'd7);

    // Randomized operations.
    for (int i = 0; i < 40; i++) begin
      logic         ro;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ro = 1'($urandom);
      ra = pick_operand();
      rb = ($urandom_range(0, 9) == 0) ? '0 : pick_operand();
      run_op(ro, ra, rb);
    end

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
